apb_gpio_ext: RTL

Parametrised APB3 GPIO peripheral, successor to the fixed 4-bit GPIO wrapper on the bootloader's peripheral APB bus. Adds per-pin runtime direction, input synchronisation with programmable debounce, atomic set/clear of outputs, and per-pin runtime-selectable interrupt mode (level high/low, rising, falling, both edges) with sticky write-1-to-clear status. Sits as an APB slave beside the UART and SPI bridges; `INT_OR` feeds the processor's external interrupt line.

---
 rtl/apb_gpio_ext.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apb_gpio_ext.sv
// APB3 GPIO peripheral: per-pin direction, synchronised and debounced inputs,
// atomic set/clear of outputs, and per-pin configurable sticky interrupts.
module apb_gpio_ext #(
  parameter int unsigned IO_NUM      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 16
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic [IO_NUM-1:0] INT,
  output logic              INT_OR
);

  localparam logic [5:0] AddrOut     = 6'd0;
  localparam logic [5:0] AddrOe      = 6'd1;
  localparam logic [5:0] AddrIn      = 6'd2;
  localparam logic [5:0] AddrIntEn   = 6'd3;
  localparam logic [5:0] AddrIntEdge = 6'd4;
  localparam logic [5:0] AddrIntPol  = 6'd5;
  localparam logic [5:0] AddrIntBoth = 6'd6;
  localparam logic [5:0] AddrStatus  = 6'd7;
  localparam logic [5:0] AddrDeb     = 6'd8;
  localparam logic [5:0] AddrSet     = 6'd9;
  localparam logic [5:0] AddrClr     = 6'd10;

  logic [5:0]        idx;
  logic              access;
  logic              err;
  logic              wr;
  logic [IO_NUM-1:0] wdata;

  logic [IO_NUM-1:0] out_q, oe_q, int_en_q, int_edge_q, int_pol_q, int_both_q, status_q;
  logic [DEB_W-1:0]  deb_q, deb_cnt_q;

  logic [SYNC_STAGES*IO_NUM-1:0] sync_q;
  logic [IO_NUM-1:0]             sync_out;
  logic [IO_NUM-1:0]             smp1_q, smp2_q, filt_q, filt_d_q;
  logic                          tick;
  logic [IO_NUM-1:0]             agree;

  logic [IO_NUM-1:0] rise, fall, edge_hit, lvl_hit, int_set, w1c;
  logic [31:0]       rdata;
  logic              unused;

  assign idx    = PADDR[7:2];
  assign access = PSEL & PENABLE;
  assign err    = access & ((idx > AddrClr) | (PWRITE & (idx == AddrIn)));
  assign wr     = access & PWRITE & ~err;
  assign wdata  = PWDATA[IO_NUM-1:0];
  assign unused = ^{PADDR[1:0], PWDATA};

  assign PREADY  = 1'b1;
  assign PSLVERR = err;

  // Output data: plain write, atomic set and atomic clear live at distinct addresses.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      out_q <= '0;
    end else if (wr && idx == AddrOut) begin
      out_q <= wdata;
    end else if (wr && idx == AddrSet) begin
      out_q <= out_q | wdata;
    end else if (wr && idx == AddrClr) begin
      out_q <= out_q & ~wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      oe_q       <= '0;
      int_en_q   <= '0;
      int_edge_q <= '0;
      int_pol_q  <= '0;
      int_both_q <= '0;
      deb_q      <= '0;
    end else if (wr) begin
      if (idx == AddrOe)      oe_q       <= wdata;
      if (idx == AddrIntEn)   int_en_q   <= wdata;
      if (idx == AddrIntEdge) int_edge_q <= wdata;
      if (idx == AddrIntPol)  int_pol_q  <= wdata;
      if (idx == AddrIntBoth) int_both_q <= wdata;
      if (idx == AddrDeb)     deb_q      <= PWDATA[DEB_W-1:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[(SYNC_STAGES-1)*IO_NUM-1:0], GPIO_IN};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES*IO_NUM-1 -: IO_NUM];
  assign tick     = (deb_cnt_q == deb_q);
  // A pin's new level is accepted only when this tick sample matches the two before it.
  assign agree    = ~(sync_out ^ smp1_q) & ~(smp1_q ^ smp2_q);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      deb_cnt_q <= '0;
    end else if ((wr && idx == AddrDeb) || tick) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      smp1_q   <= '0;
      smp2_q   <= '0;
      filt_q   <= '0;
      filt_d_q <= '0;
    end else begin
      if (tick) begin
        smp1_q <= sync_out;
        smp2_q <= smp1_q;
      end
      if (deb_q == '0) begin
        filt_q <= sync_out;
      end else if (tick) begin
        filt_q <= (agree & sync_out) | (~agree & filt_q);
      end
      filt_d_q <= filt_q;
    end
  end

  always_comb begin
    rise     = filt_q & ~filt_d_q;
    fall     = ~filt_q & filt_d_q;
    edge_hit = (int_both_q & (rise | fall)) |
               (~int_both_q & int_pol_q & rise) |
               (~int_both_q & ~int_pol_q & fall);
    lvl_hit  = ~(filt_q ^ int_pol_q);
    int_set  = int_en_q & ((int_edge_q & edge_hit) | (~int_edge_q & lvl_hit));
    w1c      = (wr && idx == AddrStatus) ? wdata : '0;
  end

  // A set in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c) | int_set;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      AddrOut:     rdata = 32'(out_q);
      AddrOe:      rdata = 32'(oe_q);
      AddrIn:      rdata = 32'(filt_q);
      AddrIntEn:   rdata = 32'(int_en_q);
      AddrIntEdge: rdata = 32'(int_edge_q);
      AddrIntPol:  rdata = 32'(int_pol_q);
      AddrIntBoth: rdata = 32'(int_both_q);
      AddrStatus:  rdata = 32'(status_q);
      AddrDeb:     rdata = 32'(deb_q);
      default:     rdata = '0;
    endcase
  end

  assign PRDATA   = PSEL ? rdata : 32'd0;
  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe_q;
  assign INT      = status_q & int_en_q;
  assign INT_OR   = |INT;

endmodule
